sample_fifo: RTL and testbench
==============================

# sample_fifo

First-word-fall-through sample buffer between the oscilloscope acquisition path and the user sample interface of `OscilloTop`. It accepts 16-bit samples from the acquisition datapath, stores up to `2**DEPTH_LOG2` of them, and presents them on the `userif_Sample*` read port drained by the flow-control side. It also reports fill level, overflow and dropped-sample count for the register/UART side.

## Interface
- `DEPTH_LOG2`, 4: log2 of storage depth. Depth is `2**DEPTH_LOG2` entries; legal range 2..10.
- `DATA_W`, 16: sample width. Must match `userif_SampleData`.
- `clk`  in  1: single clock; all logic is rising-edge.
- `reset`  in  1: asynchronous, active-low reset.
- `i_acq_enable`  in  1: when low, incoming samples are ignored; this is not counted as a drop.
- `i_sample_valid`  in  1: one-cycle qualifier for `i_sample_data`.
- `i_sample_data`  in  DATA_W: acquired sample.
- `i_flush`  in  1: synchronous empty of the buffer.
- `i_clear_overflow`  in  1: synchronous clear of `o_overflow` and `o_drop_count`.
- `userif_SampleRead`  in  1: pop request; sampled on the rising edge.
- `userif_SampleEmpty`  out  1: high when no sample is available.
- `userif_SampleData`  out  DATA_W: head sample; valid while `userif_SampleEmpty` is low.
- `o_level`  out  DEPTH_LOG2+1: current occupancy, 0..depth.
- `o_overflow`  out  1: sticky flag; set when a sample is dropped.
- `o_drop_count`  out  8: saturating count of dropped samples.

## Operation
- **Storage**
  - Circular memory with write pointer and read pointer, each DEPTH_LOG2 bits, plus an occupancy counter of DEPTH_LOG2+1 bits.
  - Pointers wrap from depth-1 to 0.
  - full = (level == depth); empty = (level == 0).
- **Write**
  - Accepted when `i_sample_valid & i_acq_enable & (!full | pop)`.
  - Data goes to mem[wptr]; wptr increments.
- **Drop**
  - Occurs when `i_sample_valid & i_acq_enable & full & !pop`.
  - Sample is discarded; `o_overflow` is set.
  - `o_drop_count` increments and saturates at 255.
- **Pop**
  - Occurs when `userif_SampleRead & !userif_SampleEmpty`; rptr increments.
  - `userif_SampleRead` while empty is ignored: no pointer change, no error.
- **Simultaneous write and pop**
  - Level is unchanged.
  - When full, the write is accepted, because the pop frees a slot in the same edge.
  - When empty, the pop is ignored and the write proceeds.
- **Flush**
  - Has priority over write and pop on the same edge.
  - wptr = rptr = level = 0; the sample presented on that edge is discarded and not counted as a drop.
  - `o_overflow` and the drop count are untouched.
- **Clear**
  - `i_clear_overflow` zeroes `o_overflow` and `o_drop_count`.
  - If a drop occurs on the same edge, the drop wins: overflow = 1, count = 1.
- **Head output**
  - `userif_SampleData` is a register holding mem[rptr] (first-word fall-through).
  - It is refreshed on every edge where the head changes: a write into an empty buffer, or a pop with level > 1.
  - It holds its last value when empty.

## Timing
- **Reset (reset = 0)**
  - `userif_SampleEmpty` = 1.
  - `userif_SampleData` = 0.
  - `o_level` = 0.
  - `o_overflow` = 0.
  - `o_drop_count` = 0.
  - Pointers = 0.
  - Memory contents are don't-care.
- **Reset mid-operation** discards all contents immediately and asynchronously. Outputs take their reset values without waiting for a clock edge.
- **Write-to-read latency**
  - Sample accepted at edge N: `userif_SampleEmpty` falls and `userif_SampleData` is valid after edge N, i.e. one cycle.
- **Pop**
  - Pop at edge N: the next sample is on `userif_SampleData` after edge N.
  - Or `userif_SampleEmpty` rises after edge N if level was 1.
  - Back-to-back pops every cycle are supported.
- **Throughput**: one write and one pop per cycle, sustained.
- **Status timing**: `o_level`, `o_overflow` and `o_drop_count` are registered and update on the same edge as the event.

## Configuration
- Macro: `SAMPLE_FIFO_DROPCNT_EN`.
- **Defined**: the 8-bit saturating drop counter is implemented as described above.
- **Undefined**: no counter is implemented and `o_drop_count` is tied to 0. `o_overflow` behaviour is unchanged.

## Test plan
- **Reset values**: hold reset low with random inputs for 5 cycles -> Empty = 1, level = 0, data = 0, overflow = 0, count = 0. Deassert reset -> these values are retained until the first write.
- **Order and latency**: write 0x0001..0x0010 on consecutive cycles with no reads (DEPTH_LOG2 = 4) -> level = 16 and 0x0001 is on the data port one cycle after the first write. Then pop 16 times back-to-back -> data 0x0001..0x0010 in order, Empty = 1 after the last pop.
- **Overflow**: with the buffer full, present 3 more valid samples -> level stays 16, overflow = 1, count = 3, and the head is still 0x0001. Pulse `i_clear_overflow` -> overflow = 0, count = 0.
- **Full write-and-pop**: with the buffer full, write 0xBEEF together with a pop -> level = 16, no drop, and 0xBEEF is read out 16 pops later.
- **Empty write-and-pop, ignored read**: with the buffer empty, write 0x1234 together with a read request -> level = 1 and data = 0x1234. A read request while empty -> no change.
- **Flush and saturation**: flush with a simultaneous write when level = 5 -> level = 0, Empty = 1, count unchanged. Then 300 drops -> count = 255.
- **Macro off**: repeat the overflow scenario with `SAMPLE_FIFO_DROPCNT_EN` undefined -> count = 0, overflow = 1.

Source files
------------

// File: rtl/sample_fifo_if.sv
// Sample stream bundle for sample_fifo.
// The master side is the acquisition/user logic; the slave side is the FIFO.
interface sample_fifo_if #(
    parameter int DATA_W = 16
);
    logic              i_acq_enable;
    logic              i_sample_valid;
    logic [DATA_W-1:0] i_sample_data;
    logic              userif_SampleRead;
    logic              userif_SampleEmpty;
    logic [DATA_W-1:0] userif_SampleData;

    modport master (
        output i_acq_enable,
        output i_sample_valid,
        output i_sample_data,
        output userif_SampleRead,
        input  userif_SampleEmpty,
        input  userif_SampleData
    );

    modport slave (
        input  i_acq_enable,
        input  i_sample_valid,
        input  i_sample_data,
        input  userif_SampleRead,
        output userif_SampleEmpty,
        output userif_SampleData
    );
endinterface

// File: rtl/sample_fifo.sv
// First-word-fall-through sample buffer with overflow flag and level reporting.
// Define SAMPLE_FIFO_DROPCNT_EN to build the 8-bit saturating dropped-sample counter.
module sample_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    sample_fifo_if.slave        sampleIf,
    input  logic                i_flush,
    input  logic                i_clear_overflow,
    output logic [DEPTH_LOG2:0] o_level,
    output logic                o_overflow,
    output logic [7:0]          o_drop_count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] ONE_LEVEL  = (DEPTH_LOG2 + 1)'(1);

    typedef logic [DEPTH_LOG2-1:0] ptr_t;

    logic [DATA_W-1:0] mem [DEPTH];
    ptr_t              wrPtr;
    ptr_t              rdPtr;
    ptr_t              rdPtrNext;
    logic [DATA_W-1:0] headData;
    logic              isFull;
    logic              isEmpty;
    logic              wrReq;
    logic              doPush;
    logic              doPop;
    logic              doDrop;

    assign isFull    = (o_level == FULL_LEVEL);
    assign isEmpty   = (o_level == '0);
    assign wrReq     = sampleIf.i_sample_valid && sampleIf.i_acq_enable;
    assign rdPtrNext = rdPtr + 1'b1;

    // Flush overrides everything, so it is folded into the event decode once here.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        doPop  = 1'b0;
        doPush = 1'b0;
        doDrop = 1'b0;
        if (!i_flush) begin
            doPop  = sampleIf.userif_SampleRead && !isEmpty;
            doPush = wrReq && (!isFull || doPop);
            doDrop = wrReq && isFull && !doPop;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state is updated with <= so every register samples pre-edge values.
        if (!reset) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            o_level <= '0;
        end else if (i_flush) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            o_level <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtrNext;
            end
            if (doPush && !doPop) begin
                o_level <= o_level + 1'b1;
            end else if (doPop && !doPush) begin
                o_level <= o_level - 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; its contents are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= sampleIf.i_sample_data;
        end
    end

    // A new sample becomes the head when nothing older remains after this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            headData <= '0;
        end else if (doPush && (isEmpty || (doPop && o_level == ONE_LEVEL))) begin
            headData <= sampleIf.i_sample_data;
        end else if (doPop && o_level > ONE_LEVEL) begin
            headData <= mem[rdPtrNext];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_overflow <= 1'b0;
        end else if (doDrop) begin
            o_overflow <= 1'b1;
        end else if (i_clear_overflow) begin
            o_overflow <= 1'b0;
        end
    end

`ifdef SAMPLE_FIFO_DROPCNT_EN
    logic [7:0] dropCount;

    // A drop coinciding with a clear restarts the count at one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dropCount <= '0;
        end else if (doDrop) begin
            if (i_clear_overflow) begin
                dropCount <= 8'd1;
            end else if (dropCount != 8'hFF) begin
                dropCount <= dropCount + 1'b1;
            end
        end else if (i_clear_overflow) begin
            dropCount <= '0;
        end
    end

    assign o_drop_count = dropCount;
`else
    assign o_drop_count = '0;
`endif

    assign sampleIf.userif_SampleEmpty = isEmpty;
    assign sampleIf.userif_SampleData  = headData;
endmodule

// File: tb/tb_sample_fifo.sv
// Self-checking bench for sample_fifo: directed scenarios plus random traffic
// compared against a queue-based model of the buffer.
`timescale 1ns/1ps
module tb_sample_fifo;
    localparam int DEPTH_LOG2 = 4;
    localparam int DATA_W     = 16;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
`ifdef SAMPLE_FIFO_DROPCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                i_flush;
    logic                i_clear_overflow;
    logic [DEPTH_LOG2:0] o_level;
    logic                o_overflow;
    logic [7:0]          o_drop_count;

    sample_fifo_if #(.DATA_W(DATA_W)) sIf ();

    sample_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .DATA_W    (DATA_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .sampleIf        (sIf.slave),
        .i_flush         (i_flush),
        .i_clear_overflow(i_clear_overflow),
        .o_level         (o_level),
        .o_overflow      (o_overflow),
        .o_drop_count    (o_drop_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the buffer is a queue, head is its front element.
    int modelQ[$];
    bit modelOvf;
    int modelCnt;
    int lastHead;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void modelReset();
        modelQ.delete();
        modelOvf = 1'b0;
        modelCnt = 0;
        lastHead = 0;
    endfunction

    function automatic void modelEdge(input bit acq, input bit vld, input logic [15:0] data,
                                      input bit rd, input bit fl, input bit clr);
        bit dropped = 1'b0;
        if (fl) begin
            modelQ.delete();
        end else begin
            if (rd && modelQ.size() > 0) begin
                void'(modelQ.pop_front());
            end
            if (acq && vld) begin
                if (modelQ.size() < DEPTH) modelQ.push_back(int'(data));
                else dropped = 1'b1;
            end
        end
        if (dropped) begin
            modelOvf = 1'b1;
            modelCnt = clr ? 1 : ((modelCnt < 255) ? modelCnt + 1 : 255);
        end else if (clr) begin
            modelOvf = 1'b0;
            modelCnt = 0;
        end
        if (modelQ.size() > 0) lastHead = modelQ[0];
    endfunction

    task automatic checkAll(input string tag);
        check({tag, ".level"}, 32'(o_level), 32'(modelQ.size()));
        check({tag, ".empty"}, 32'(sIf.userif_SampleEmpty), 32'(modelQ.size() == 0));
        check({tag, ".data"}, 32'(sIf.userif_SampleData),
              32'((modelQ.size() > 0) ? modelQ[0] : lastHead));
        check({tag, ".overflow"}, 32'(o_overflow), 32'(modelOvf));
        check({tag, ".count"}, 32'(o_drop_count), 32'(CNT_EN ? modelCnt : 0));
    endtask

    task automatic step(input string tag, input bit acq, input bit vld, input logic [15:0] data,
                        input bit rd, input bit fl, input bit clr);
        sIf.i_acq_enable      = acq;
        sIf.i_sample_valid    = vld;
        sIf.i_sample_data     = data;
        sIf.userif_SampleRead = rd;
        i_flush               = fl;
        i_clear_overflow      = clr;
        @(posedge clk);
        modelEdge(acq, vld, data, rd, fl, clr);
        #1;
        checkAll(tag);
    endtask

    task automatic driveRandom();
        sIf.i_acq_enable      = 1'($urandom);
        sIf.i_sample_valid    = 1'($urandom);
        sIf.i_sample_data     = 16'($urandom);
        sIf.userif_SampleRead = 1'($urandom);
        i_flush               = 1'($urandom);
        i_clear_overflow      = 1'($urandom);
    endtask

    initial begin
        reset = 1'b0;
        driveRandom();
        modelReset();

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            driveRandom();
            @(posedge clk);
            #1;
            checkAll("reset_hold");
        end
        sIf.i_acq_enable = 1'b1;
        sIf.i_sample_valid = 1'b0;
        sIf.i_sample_data = '0;
        sIf.userif_SampleRead = 1'b0;
        i_flush = 1'b0;
        i_clear_overflow = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) step("post_reset", 1, 0, 16'h0, 0, 0, 0);

        // Order and latency
        for (int i = 1; i <= DEPTH; i++) begin
            step("fill", 1, 1, 16'(i), 0, 0, 0);
            if (i == 1) check("first_latency", 32'(sIf.userif_SampleData), 32'h0001);
        end
        check("full_level", 32'(o_level), 32'd16);

        // Overflow while full
        for (int i = 0; i < 3; i++) step("overflow", 1, 1, 16'(16'hD000 + i), 0, 0, 0);
        check("overflow_head", 32'(sIf.userif_SampleData), 32'h0001);
        check("overflow_count", 32'(o_drop_count), CNT_EN ? 32'd3 : 32'd0);
        step("clear", 1, 0, 16'h0, 0, 0, 1);

        // Full write-and-pop, then drain
        step("full_wr_pop", 1, 1, 16'hBEEF, 1, 0, 0);
        check("full_wr_pop_ovf", 32'(o_overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            step("drain", 1, 0, 16'h0, 1, 0, 0);
            if (i == DEPTH - 2) check("beef_head", 32'(sIf.userif_SampleData), 32'hBEEF);
        end

        // Empty write-and-pop, ignored read
        step("empty_wr_rd", 1, 1, 16'h1234, 1, 0, 0);
        check("empty_wr_rd_data", 32'(sIf.userif_SampleData), 32'h1234);
        step("pop_last", 1, 0, 16'h0, 1, 0, 0);
        step("rd_empty", 1, 0, 16'h0, 1, 0, 0);
        step("rd_empty", 1, 0, 16'h0, 1, 0, 0);

        // Flush with simultaneous write, then saturation
        for (int i = 0; i < 5; i++) step("fill5", 1, 1, 16'(16'h0A00 + i), 0, 0, 0);
        step("flush_wr", 1, 1, 16'h5555, 1, 1, 0);
        check("flush_level", 32'(o_level), 32'd0);
        for (int i = 0; i < DEPTH; i++) step("refill", 1, 1, 16'(16'h0B00 + i), 0, 0, 0);
        for (int i = 0; i < 300; i++) step("sat", 1, 1, 16'(i), 0, 0, 0);
        check("sat_count", 32'(o_drop_count), CNT_EN ? 32'd255 : 32'd0);
        step("drop_and_clear", 1, 1, 16'h7777, 0, 0, 1);
        step("flush_full_drop", 1, 1, 16'h8888, 0, 1, 0);
        for (int i = 0; i < 4; i++) step("acq_off", 0, 1, 16'(16'hC000 + i), 0, 0, 0);

        // Random traffic in phases biased toward filling, balanced, and draining
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 1000; i++) begin
                step("random",
                     $urandom_range(0, 9) != 0,
                     $urandom_range(0, 3) != 0,
                     16'($urandom),
                     $urandom_range(0, 3) < (p + 1),
                     $urandom_range(0, 99) == 0,
                     $urandom_range(0, 49) == 0);
            end
        end

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 6; i++) step("pre_async", 1, 1, 16'(16'hE000 + i), 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        checkAll("async_reset");
        @(posedge clk);
        #1;
        checkAll("async_hold");
        reset = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step("post_async",
                 1'b1,
                 $urandom_range(0, 1) == 1,
                 16'($urandom),
                 $urandom_range(0, 2) == 0,
                 1'b0,
                 $urandom_range(0, 29) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
